// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and access codes for the dual-port RAM controller
package ram_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;
endpackage

// File: rtl/ram_port_fsm.sv
// ram_port_fsm: per-port request latch, wait counter and IDLE/WAIT/RESP handshake FSM
module ram_port_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int WAIT_CYCLES = 0,
  parameter bit WR_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [1:0]        rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [BE_W-1:0]   be_o
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        rw_q;
  logic              ack_q, err_q, accept, fire, legal;
  always_comb begin
    accept  = state_q == ST_IDLE && req_i;
    fire    = state_q == ST_WAIT && cnt_q == 4'd0;
    legal   = rw_q == RW_READ || (WR_EN && rw_q == RW_WRITE);
    state_d = state_q == ST_IDLE ? (req_i ? ST_WAIT : ST_IDLE)
            : state_q == ST_WAIT ? (fire ? ST_RESP : ST_WAIT) : ST_IDLE;
    cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == ST_WAIT && !fire) ? cnt_q - 4'd1 : cnt_q;
  end
  // a reset on the access edge must suppress the array strobes too, so the write is dropped
  assign rd_o   = fire && !reset && rw_q == RW_READ;
  assign wr_o   = fire && !reset && WR_EN && rw_q == RW_WRITE;
  assign busy_o = state_q != ST_IDLE;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= fire;
      err_q   <= fire && !legal;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= rw_i;
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      be_o    <= be_i;
    end
  end
endmodule

// File: rtl/ram_dp_ctrl.sv
// ram_dp_ctrl: dual-port word RAM with wait-state-timed fetch (read-only) and data (read/write) ports
// Define RAM_BYTE_MASK_EN to add the d_be byte-write mask on the data port.
module ram_dp_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_busy,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic [1:0]        d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
`ifdef RAM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] d_be,
`endif
  output logic              d_busy,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata
);
`ifdef RAM_BYTE_MASK_EN
  localparam int BE_W = DATA_W / 8;
  logic [BE_W-1:0] be_in;
  assign be_in = d_be;
`else
  localparam int BE_W = 1;
  logic [BE_W-1:0] be_in;
  assign be_in = 1'b1;
`endif
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              i_rd, i_wr, i_err;
  logic [ADDR_W-1:0] i_addr_l, d_addr_l;
  logic [DATA_W-1:0] i_wdata_l, d_wdata_l, i_data_q, d_rdata_q;
  logic [BE_W-1:0]   i_be_l, d_be_l;
  logic              d_rd, d_wr;
  ram_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .WAIT_CYCLES(WAIT_CYCLES), .WR_EN(1'b0)) u_fetch (
    .clk(clk), .reset(reset), .req_i(i_req), .rw_i(RW_READ), .addr_i(i_addr), .wdata_i('0),
    .be_i('1), .busy_o(i_busy), .ack_o(i_valid), .err_o(i_err), .rd_o(i_rd), .wr_o(i_wr),
    .addr_o(i_addr_l), .wdata_o(i_wdata_l), .be_o(i_be_l)
  );
  ram_port_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .WAIT_CYCLES(WAIT_CYCLES), .WR_EN(1'b1)) u_data (
    .clk(clk), .reset(reset), .req_i(d_req), .rw_i(d_rw), .addr_i(d_addr), .wdata_i(d_wdata),
    .be_i(be_in), .busy_o(d_busy), .ack_o(d_ack), .err_o(d_err), .rd_o(d_rd), .wr_o(d_wr),
    .addr_o(d_addr_l), .wdata_o(d_wdata_l), .be_o(d_be_l)
  );
  // both reads sample the array before this edge's write lands, giving read-before-write
  always_ff @(posedge clk) begin
    if (reset) begin
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rd) i_data_q <= mem[i_addr_l];
      if (d_rd) d_rdata_q <= mem[d_addr_l];
    end
  end
  always_ff @(posedge clk) begin
`ifdef RAM_BYTE_MASK_EN
    if (d_wr)
      for (int b = 0; b < BE_W; b++)
        if (d_be_l[b]) mem[d_addr_l][b*8 +: 8] <= d_wdata_l[b*8 +: 8];
`else
    if (d_wr) mem[d_addr_l] <= d_wdata_l;
`endif
  end
  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_ram_dp_ctrl.sv
// tb_ram_dp_ctrl: randomized self-checking bench for ram_dp_ctrl against a word-array reference model
module tb_ram_dp_ctrl;
  localparam int W = 2;
  logic        clk = 1'b0, reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [1:0]  d_rw = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = 4'hF;
  logic        i_busy, i_valid, d_busy, d_ack, d_err;
  logic [31:0] i_data, d_rdata;
  int tests = 0, fails = 0;
  logic [31:0] mm [int];
  logic [31:0] last_d = '0, last_i = '0;

  ram_dp_ctrl #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy),
    .i_valid(i_valid), .i_data(i_data), .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr),
    .d_wdata(d_wdata),
`ifdef RAM_BYTE_MASK_EN
    .d_be(d_be),
`endif
    .d_busy(d_busy), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
`ifdef RAM_BYTE_MASK_EN
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
`else
    r = nw;
`endif
    return r;
  endfunction

  // Drives one data access, applies it to the model and returns what the port showed.
  task automatic d_op(input logic [1:0] rw, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be,
                      output int lat, output logic [31:0] rd, output logic err, output logic pulse_after);
    @(negedge clk);
    d_req = 1'b1; d_rw = rw; d_addr = a; d_wdata = wd; d_be = be;
    @(posedge clk); #1;
    d_req = 1'b0; d_rw = 2'($urandom); d_addr = 16'($urandom); d_wdata = $urandom; d_be = 4'($urandom);
    lat = -1; rd = 'x; err = 1'bx;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (d_ack) begin lat = n; rd = d_rdata; err = d_err; break; end
    end
    @(negedge clk);
    pulse_after = d_ack | d_err;
    if (rw == 2'b01) last_d = mm.exists(int'(a)) ? mm[int'(a)] : 'x;
    else if (rw == 2'b10) mm[int'(a)] = merge(mm.exists(int'(a)) ? mm[int'(a)] : 32'h0, wd, be);
  endtask

  task automatic f_op(input logic [15:0] a, output int lat, output logic [31:0] rd);
    @(negedge clk);
    i_req = 1'b1; i_addr = a;
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = 16'($urandom);
    lat = -1; rd = 'x;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (i_valid) begin lat = n; rd = i_data; break; end
    end
    @(negedge clk);
    last_i = mm[int'(a)];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({i_busy, i_valid, d_busy, d_ack, d_err} !== 5'b0 || i_data !== 32'h0 || d_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_state: busy/valid/ack/err=%b i_data=%h d_rdata=%h, want all 0",
                        {i_busy, i_valid, d_busy, d_ack, d_err}, i_data, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd; logic err, pa;
    d_op(2'b10, 16'h0010, 32'hDEADBEEF, 4'hF, lat, rd, err, pa);
    tests++; if (lat !== W + 2) begin fails++; $display("FAIL wr_latency: got %0d want %0d", lat, W + 2); end
    tests++; if (rd !== last_d) begin fails++; $display("FAIL wr_rdata_held: got %h want %h", rd, last_d); end
    d_op(2'b01, 16'h0010, 32'h0, 4'hF, lat, rd, err, pa);
    tests++; if (lat !== W + 2) begin fails++; $display("FAIL rd_latency: got %0d want %0d", lat, W + 2); end
    tests++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin fails++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, err); end
    tests++; if (pa !== 1'b0) begin fails++; $display("FAIL ack_one_cycle: ack/err still high next cycle, want low"); end
  endtask

  task automatic test_same_edge;
    int li, ld; logic [31:0] ri; int lat; logic [31:0] rd;
    logic [31:0] old;
    old = mm[16'h0010];
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_rw = 2'b10; d_addr = 16'h0010; d_wdata = 32'h12345678;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    li = -1; ld = -1; ri = 'x;
    for (int n = 1; n <= 50 && (li < 0 || ld < 0); n++) begin
      @(negedge clk);
      if (i_valid) begin li = n; ri = i_data; end
      if (d_ack) ld = n;
    end
    @(negedge clk);
    mm[16'h0010] = 32'h12345678;
    tests++; if (li !== W + 2 || ld !== W + 2) begin fails++; $display("FAIL same_edge_latency: fetch %0d data %0d want %0d", li, ld, W + 2); end
    tests++; if (ri !== old) begin fails++; $display("FAIL same_edge_old_word: got %h want %h", ri, old); end
    f_op(16'h0010, lat, rd);
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL fetch_new_word: got %h want 12345678", rd); end
  endtask

  task automatic test_illegal;
    int lat; logic [31:0] rd, prev; logic err, pa;
    d_op(2'b10, 16'h0020, 32'hA5A5A5A5, 4'hF, lat, rd, err, pa);
    d_op(2'b01, 16'h0044, 32'h0, 4'hF, lat, rd, err, pa);
    prev = last_d;
    d_op(2'b11, 16'h0020, 32'h0F0F0F0F, 4'hF, lat, rd, err, pa);
    tests++; if (lat !== W + 2 || err !== 1'b1) begin fails++; $display("FAIL illegal_ack_err: lat %0d err %b want %0d err 1", lat, err, W + 2); end
    tests++; if (rd !== prev || pa !== 1'b0) begin fails++; $display("FAIL illegal_side_effect: rdata %h pulse_after %b want %h 0", rd, pa, prev); end
    d_op(2'b01, 16'h0020, 32'h0, 4'hF, lat, rd, err, pa);
    tests++; if (rd !== 32'hA5A5A5A5 || err !== 1'b0) begin fails++; $display("FAIL illegal_no_write: got %h err %b want a5a5a5a5 0", rd, err); end
  endtask

  task automatic test_reset_in_wait;
    int lat; logic [31:0] rd; logic err, pa;
    d_op(2'b10, 16'h0030, 32'h77777777, 4'hF, lat, rd, err, pa);
    f_op(16'h0030, lat, rd);
    @(negedge clk);
    d_req = 1'b1; d_rw = 2'b10; d_addr = 16'h0030; d_wdata = 32'h0BADF00D; d_be = 4'hF;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    tests++; if (d_busy !== 1'b1) begin fails++; $display("FAIL busy_in_wait: got %b want 1", d_busy); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({i_busy, i_valid, d_busy, d_ack, d_err} !== 5'b0 || i_data !== 32'h0 || d_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_mid_wait: flags=%b i_data=%h d_rdata=%h want all 0",
                        {i_busy, i_valid, d_busy, d_ack, d_err}, i_data, d_rdata);
    end
    reset = 1'b0;
    last_d = '0; last_i = '0;
    repeat (W + 3) @(negedge clk);
    tests++; if (d_ack !== 1'b0 || d_busy !== 1'b0) begin fails++; $display("FAIL dropped_write_ack: ack %b busy %b want 0 0", d_ack, d_busy); end
    d_op(2'b01, 16'h0030, 32'h0, 4'hF, lat, rd, err, pa);
    tests++; if (rd !== 32'h77777777) begin fails++; $display("FAIL write_dropped: got %h want 77777777", rd); end
  endtask

  task automatic test_byte_mask;
`ifdef RAM_BYTE_MASK_EN
    int lat; logic [31:0] rd; logic err, pa;
    d_op(2'b10, 16'h0050, 32'h11223344, 4'hF, lat, rd, err, pa);
    d_op(2'b10, 16'h0050, 32'hAABBCCDD, 4'b0101, lat, rd, err, pa);
    d_op(2'b01, 16'h0050, 32'h0, 4'hF, lat, rd, err, pa);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL byte_mask: got %h want 11bb33dd", rd); end
    d_op(2'b10, 16'h0050, 32'hFFFFFFFF, 4'b0000, lat, rd, err, pa);
    tests++; if (lat !== W + 2 || err !== 1'b0) begin fails++; $display("FAIL be_zero_ack: lat %0d err %b", lat, err); end
    d_op(2'b01, 16'h0050, 32'h0, 4'hF, lat, rd, err, pa);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL be_zero_nochange: got %h want 11bb33dd", rd); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat, k, t_prev; logic [31:0] rd; logic err, pa;
    logic [15:0] seq [4];
    seq = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    d_op(2'b10, 16'hFFFF, 32'hC0FFEE01, 4'hF, lat, rd, err, pa);
    d_op(2'b10, 16'h0000, 32'hFACE0002, 4'hF, lat, rd, err, pa);
    @(negedge clk);
    d_req = 1'b1; d_rw = 2'b01; d_addr = seq[0]; d_be = 4'hF;
    k = 0; t_prev = 0;
    for (int n = 1; n <= 60 && k < 4; n++) begin
      @(negedge clk);
      if (d_ack) begin
        tests++;
        if (n - t_prev !== (k == 0 ? W + 2 : W + 3) || d_rdata !== mm[int'(seq[k])]) begin
          fails++; $display("FAIL b2b_%0d: gap %0d data %h want gap %0d data %h", k, n - t_prev, d_rdata,
                            k == 0 ? W + 2 : W + 3, mm[int'(seq[k])]);
        end
        t_prev = n; k++;
        if (k == 4) d_req = 1'b0; else d_addr = seq[k];
      end
    end
    last_d = mm[0];
    tests++; if (k !== 4) begin fails++; $display("FAIL b2b_count: got %0d acks want 4", k); end
    repeat (2) @(negedge clk);
    tests++; if (d_busy !== 1'b0 || d_ack !== 1'b0) begin fails++; $display("FAIL b2b_no_extra: busy %b ack %b want 0 0", d_busy, d_ack); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, exp_rd, wd; logic err, pa; logic [1:0] rw; logic [15:0] a; logic [3:0] be;
    for (int i = 0; i < 8; i++) d_op(2'b10, 16'h0100 + 16'(i), $urandom, 4'hF, lat, rd, err, pa);
    for (int i = 0; i < 40; i++) begin
      rw = 2'($urandom); a = 16'h0100 + 16'($urandom_range(0, 7)); wd = $urandom; be = 4'($urandom);
      exp_rd = rw == 2'b01 ? mm[int'(a)] : last_d;
      d_op(rw, a, wd, be, lat, rd, err, pa);
      tests++;
      if (lat !== W + 2 || rd !== exp_rd || err !== (rw == 2'b00 || rw == 2'b11) || pa !== 1'b0) begin
        fails++; $display("FAIL rand_d_%0d: rw %b addr %h lat %0d rdata %h err %b want lat %0d rdata %h err %b",
                          i, rw, a, lat, rd, err, W + 2, exp_rd, rw == 2'b00 || rw == 2'b11);
      end
      if (i % 4 == 0) begin
        a = 16'h0100 + 16'($urandom_range(0, 7));
        f_op(a, lat, rd);
        tests++;
        if (lat !== W + 2 || rd !== mm[int'(a)]) begin
          fails++; $display("FAIL rand_f_%0d: addr %h lat %0d data %h want %0d %h", i, a, lat, rd, W + 2, mm[int'(a)]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_same_edge;
    test_illegal;
    test_reset_in_wait;
    test_byte_mask;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
